instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Upstream neighbour of the single-cycle datapath. Replaces the direct PC-to-instrMem hookup.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory over a req/ack handshake.
- Buffers returned {pc, instr} pairs in a small FIFO and delivers them to decode over valid/ready.
- Accepts a redirect from the datapath on a taken branch, jump, jal or jr. A redirect flushes the queue and kills any in-flight fetch.

Parameters:
- n, 32: word and address width.
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- CLK  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- redirect  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  n  new fetch target; must be word-aligned.
- imem_req  output  1  memory request, held until imem_ack.
- imem_addr  output  n  request address, stable while imem_req=1.
- imem_ack  input  1  one-cycle acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  input  n  fetched instruction word.
- instr_valid  output  1  queue head is valid.
- instr  output  n  head instruction.
- instr_pc  output  n  address of the head instruction.
- instr_ready  input  1  decode consumes the head on the rising edge where instr_valid=1 and instr_ready=1.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, fetch_pc=RESET_PC, FIFO count=0, read/write pointers=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- FSM states:
  - IDLE: no request outstanding. Go to WAIT when count<DEPTH and redirect=0.
  - WAIT: imem_req=1, imem_addr=fetch_pc.
    - On imem_ack: push {fetch_pc, imem_rdata}; fetch_pc += 4 (mod 2^n).
    - Stay in WAIT if post-update count<DEPTH, else go to IDLE.
  - DISCARD: a killed request is still outstanding. imem_req=1 and imem_addr keep the old address.
    - On imem_ack: drop the data, then go to IDLE, or directly to WAIT at the new fetch_pc if space.
- Handshake:
  - imem_req is never dropped before imem_ack.
  - imem_addr does not change while imem_req=1.
- Latency:
  - imem_ack in cycle N → word visible at the FIFO head in cycle N+1 (registered storage).
  - After reset release, first imem_req is seen one cycle later.
  - With a zero-wait memory, sustained throughput is one word per cycle.
- FIFO rules:
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Full (count=DEPTH): no new request is issued. A push cannot occur when full because issue is space-checked.
  - Empty: instr_valid=0. instr and instr_pc hold their last values (don't-care).
  - Pointers wrap modulo DEPTH. fetch_pc wraps from 32'hFFFF_FFFC to 0.
- Redirect (priority over push/pop in the same cycle):
  - count is cleared and pointers reset. Any pop that cycle is ignored; any ack'd data that cycle is dropped.
  - fetch_pc is set to redirect_pc.
  - From WAIT without ack → DISCARD.
  - From WAIT with ack → the killed fetch is complete, so go to IDLE.
  - From IDLE → IDLE.
  - From DISCARD → DISCARD, with fetch_pc updated again (last redirect wins).
  - instr_valid=0 in the cycle after a redirect.
- Reset mid-operation: immediate return to the reset state; an outstanding memory access is abandoned (memory is reset by the same rst).

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds 32-bit outputs stat_fetched and stat_killed.
  - stat_fetched counts every pushed word.
  - stat_killed counts dropped words: flushed FIFO entries plus discarded acks.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, WAIT, DISCARD}.
  - localparam PC_STEP=4.
  - Typedef fetch_entry_t = struct {logic [31:0] pc; logic [31:0] instr;}.
- Sub-module fetch_fifo:
  - Parameterised DEPTH; push, pop and flush inputs; full, empty and count outputs.
  - Stores fetch_entry_t.
- The top level holds the FSM and fetch_pc only.

Test Plan:
- Reset release, zero-wait memory returning data=addr^32'hA5A5_0000, instr_ready=1 → imem_addr sequence 0,4,8,…; instr_pc/instr pairs appear in order, starting one cycle after the first ack.
- instr_ready=0 held → exactly 4 requests (addresses 0–12), then imem_req=0. Raise ready → the four pops occur, then refill resumes at 16.
- 3-cycle ack latency, redirect to 32'h0000_0100 one cycle after issuing addr 8 → state goes to DISCARD; the ack for 8 is dropped; the next request is 0x100; no word with pc=8 is ever delivered.
- Redirect in the same cycle as imem_ack and a pop with count=2 → count=0, next request at redirect_pc, instr_valid=0 in the next cycle.
- Redirect to 32'hFFFF_FFF8 → fetches FFFF_FFF8, FFFF_FFFC, then 0000_0000.
- Assert rst while in WAIT with count=3 → all outputs return to reset values immediately. With FETCH_STATS_EN defined, stat_fetched=0 and stat_killed=0.

Source files
------------

// File: rtl/instr_fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fetch_pkg
// Description : Shared types and helpers for the instruction fetch queue:
//               FSM state encoding, the buffered {pc, instr} entry and a
//               saturating counter increment.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Add a small increment to a 32-bit counter, clamping at all-ones.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_queue_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Registered FIFO of fetch_entry_t with synchronous flush.
//               Flush wins over push/pop in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t       r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^k).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Owns the fetch PC, issues word requests over a req/ack
//               handshake and buffers {pc, instr} pairs for decode.
//               Redirect flushes the queue and kills any in-flight fetch.
//               Optional: define FETCH_STATS_EN for stat_fetched/stat_killed.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int           n        = 32,
    parameter int           DEPTH    = 4,
    parameter logic [n-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         redirect,
    input  logic [n-1:0] redirect_pc,
    output logic         imem_req,
    output logic [n-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [n-1:0] imem_rdata,
    output logic         instr_valid,
    output logic [n-1:0] instr,
    output logic [n-1:0] instr_pc,
    input  logic         instr_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]  stat_fetched,
    output logic [31:0]  stat_killed
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t   r_state;
    fetch_state_t   w_state_next;
    logic [n-1:0]   r_fetch_pc;
    logic [n-1:0]   w_fetch_pc_next;
    logic [n-1:0]   r_addr;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic [CW-1:0]  w_count;
    logic [CW-1:0]  w_count_on_ack;
    fetch_entry_t   w_head;
    fetch_entry_t   w_push_data;

    assign w_pop          = !w_empty && instr_ready;
    assign w_count_on_ack = w_count + CW'(1) - CW'(w_pop);
    assign w_push_data    = '{pc: 32'(r_fetch_pc), instr: 32'(imem_rdata)};

    assign imem_req    = (r_state != IDLE);
    assign imem_addr   = r_addr;
    assign instr_valid = !w_empty;
    assign instr       = n'(w_head.instr);
    assign instr_pc    = n'(w_head.pc);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (rst),
        .flush     (redirect),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Next-state, push decision and next fetch PC.
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!redirect && !w_full) w_state_next = WAIT;
            end
            WAIT: begin
                if (redirect) begin
                    // An ack in the redirect cycle completes the killed fetch.
                    w_state_next = imem_ack ? IDLE : DISCARD;
                end else if (imem_ack) begin
                    w_push       = 1'b1;
                    w_state_next = (w_count_on_ack < CW'(DEPTH)) ? WAIT : IDLE;
                end
            end
            DISCARD: begin
                if (imem_ack) w_state_next = (!redirect && !w_full) ? WAIT : IDLE;
            end
            default: w_state_next = IDLE;
        endcase

        if (redirect)    w_fetch_pc_next = redirect_pc;
        else if (w_push) w_fetch_pc_next = r_fetch_pc + n'(PC_STEP);
        else             w_fetch_pc_next = r_fetch_pc;
    end

    // State, fetch PC and request address; the address only moves on entry to
    // or advance within WAIT, so it holds through DISCARD.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            if (w_state_next == WAIT) r_addr <= w_fetch_pc_next;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] w_dropped;

    assign w_dropped = (redirect ? 32'(w_count) : 32'd0)
                     + 32'(imem_ack && ((r_state == DISCARD) || (r_state == WAIT && redirect)));

    // Saturating counts of pushed words and of flushed/discarded words.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            stat_fetched <= '0;
            stat_killed  <= '0;
        end else begin
            stat_fetched <= sat_add(stat_fetched, 32'(w_push));
            stat_killed  <= sat_add(stat_killed, w_dropped);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Scoreboard bench for instr_fetch_queue with a variable-latency
//               memory model returning addr ^ 32'hA5A5_0000.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    int          total = 0;
    int          bad = 0;
    int          lat = 0;
    int          ack_cnt = 0;
    logic [31:0] exp_pc [$];
    logic [31:0] exp_ins [$];

    instr_fetch_queue #(.n(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .CLK         (CLK),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_word(input logic [31:0] pc);
        exp_pc.push_back(pc);
        exp_ins.push_back(pc ^ KEY);
    endtask

    // Memory model: acks after lat wait cycles, checks request hold/stability.
    initial begin
        int          cnt = 0;
        logic        pending = 1'b0;
        logic [31:0] prev_addr = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (rst || !imem_req) begin
                if (!rst && pending) check("req_hold", {31'd0, imem_req}, 32'd1);
                imem_ack = 1'b0;
                cnt      = 0;
                pending  = 1'b0;
            end else begin
                if (pending) check("addr_stable", imem_addr, prev_addr);
                if (cnt == lat) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr ^ KEY;
                    ack_cnt++;
                    cnt        = 0;
                    pending    = 1'b0;
                end else begin
                    imem_ack  = 1'b0;
                    cnt++;
                    pending   = 1'b1;
                    prev_addr = imem_addr;
                end
            end
        end
    end

    // Monitor: every consumed head word must match the scoreboard front.
    initial begin
        forever begin
            @(negedge CLK);
            if (!rst && instr_valid && instr_ready && !redirect) begin
                if (exp_pc.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got pc %h instr %h want none", instr_pc, instr);
                end else begin
                    check("deliver_pc", instr_pc, exp_pc.pop_front());
                    check("deliver_instr", instr, exp_ins.pop_front());
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge CLK);
        #1;
        rst = 1'b1;
        instr_ready = 1'b0;
        redirect = 1'b0;
        repeat (2) @(posedge CLK);
        exp_pc.delete();
        exp_ins.delete();
        ack_cnt = 0;
    endtask

    task automatic release_reset();
        @(posedge CLK);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge CLK);
            if (exp_pc.size() == 0) break;
        end
        #1;
        instr_ready = 1'b0;
        check("drain_left", exp_pc.size(), 32'd0);
    endtask

    initial begin
        // Reset values
        @(negedge CLK);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);

        // Streaming with zero-wait memory
        lat = 0;
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) expect_word(32'(i * 4));
        release_reset();
        @(negedge CLK);
        check("t1_req_idle", {31'd0, imem_req}, 32'd0);
        @(negedge CLK);
        check("t1_req_first", {31'd0, imem_req}, 32'd1);
        check("t1_addr_first", imem_addr, 32'h0);
        check("t1_valid_early", {31'd0, instr_valid}, 32'd0);
        @(negedge CLK);
        check("t1_valid_next", {31'd0, instr_valid}, 32'd1);
        drain(100);

        // Backpressure: fill to four, then release
        apply_reset();
        lat = 0;
        release_reset();
        repeat (10) @(negedge CLK);
        check("t2_acks", 32'(ack_cnt), 32'd4);
        check("t2_req_full", {31'd0, imem_req}, 32'd0);
        check("t2_head_pc", instr_pc, 32'h0);
        for (int i = 0; i < 8; i++) expect_word(32'(i * 4));
        @(posedge CLK);
        #1;
        instr_ready = 1'b1;
        drain(100);

        // Redirect while a slow fetch of 8 is outstanding
        apply_reset();
        lat = 3;
        instr_ready = 1'b1;
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h100);
        expect_word(32'h104);
        expect_word(32'h108);
        release_reset();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 60 && !seen; i++) begin
                @(negedge CLK);
                if (imem_req && imem_addr == 32'h8) seen = 1'b1;
            end
            check("t3_saw_addr8", {31'd0, seen}, 32'd1);
        end
        @(posedge CLK);
        #2;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        @(posedge CLK);
        #2;
        redirect = 1'b0;
        @(negedge CLK);
        check("t3_disc_req", {31'd0, imem_req}, 32'd1);
        check("t3_disc_addr", imem_addr, 32'h8);
        check("t3_disc_valid", {31'd0, instr_valid}, 32'd0);
        begin
            bit moved = 1'b0;
            for (int i = 0; i < 20 && !moved; i++) begin
                @(negedge CLK);
                if (imem_req && imem_addr != 32'h8) moved = 1'b1;
            end
            check("t3_next_addr", imem_addr, 32'h100);
        end
        drain(100);

        // Redirect coinciding with ack and pop at count=2
        apply_reset();
        lat = 0;
        release_reset();
        @(posedge CLK);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        instr_ready = 1'b1;
        expect_word(32'h200);
        expect_word(32'h204);
        expect_word(32'h208);
        @(negedge CLK);
        check("t4_ack", {31'd0, imem_ack}, 32'd1);
        check("t4_addr", imem_addr, 32'h8);
        check("t4_valid_pre", {31'd0, instr_valid}, 32'd1);
        @(posedge CLK);
        #2;
        redirect = 1'b0;
        @(negedge CLK);
        check("t4_valid_post", {31'd0, instr_valid}, 32'd0);
        check("t4_req_idle", {31'd0, imem_req}, 32'd0);
        @(negedge CLK);
        check("t4_req_new", {31'd0, imem_req}, 32'd1);
        check("t4_addr_new", imem_addr, 32'h200);
        drain(100);

        // PC wrap at the top of the address space
        apply_reset();
        lat = 0;
        instr_ready = 1'b1;
        expect_word(32'hFFFF_FFF8);
        expect_word(32'hFFFF_FFFC);
        expect_word(32'h0000_0000);
        expect_word(32'h0000_0004);
        @(posedge CLK);
        #1;
        rst = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        @(posedge CLK);
        #1;
        redirect = 1'b0;
        drain(100);

        // Asynchronous reset in WAIT with three words queued
        apply_reset();
        lat = 0;
        release_reset();
        repeat (4) @(posedge CLK);
        #2;
        check("t6_req_pre", {31'd0, imem_req}, 32'd1);
        check("t6_valid_pre", {31'd0, instr_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_req", {31'd0, imem_req}, 32'd0);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_valid", {31'd0, instr_valid}, 32'd0);
        check("t6_instr", instr, 32'h0);
        check("t6_instr_pc", instr_pc, 32'h0);

        repeat (2) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
